mem_access_unit: RTL and testbench

Load/store sequencer between the execute stage and the 32×8 data memory. Accepts one memory request at a time over a valid/ready handshake, drives the memory's address, write-data, write-enable and read-enable lines, and returns the result over a valid/ready response channel. Supports load, store and atomic fetch-and-add (read-modify-write) on 8-bit words.

---
 rtl/mem_access_unit.sv | 126 ++++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store/fetch-and-add sequencer in front of a 32x8 data memory.
// Optional MEM_BOUNDS_CHECK_EN rejects out-of-range addresses with rsp_err instead of touching memory.
module mem_access_unit #(
  parameter int unsigned DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_write,
  output logic       mem_read,
  input  logic [7:0] mem_rdata
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FADD  = 2'b10;

  // An 8-bit address can never reach DEPTH outside this range.
  if (DEPTH == 0 || DEPTH > 256) begin : g_depth_guard
    $error("mem_access_unit: DEPTH must be in 1..256");
  end

  logic [1:0] state_reg, state_next;
  logic [1:0] op_reg;
  logic [7:0] addr_reg;
  logic [7:0] wdata_reg;
  logic [7:0] rdata_reg;
  logic [1:0] op_norm;
  logic [7:0] fadd_sum;
  logic       out_of_range;

  // The reserved encoding behaves exactly like a load.
  assign op_norm  = (req_op == 2'b11) ? OP_LOAD : req_op;
  assign fadd_sum = rdata_reg + wdata_reg;

`ifdef MEM_BOUNDS_CHECK_EN
  logic err_reg;

  assign out_of_range = ({24'd0, req_addr} >= DEPTH);
  assign rsp_err      = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (state_reg == IDLE && req_valid) begin
      err_reg <= out_of_range;
    end
  end
`else
  assign out_of_range = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (out_of_range)              state_next = RESP;
          else if (op_norm == OP_STORE)  state_next = WRITE;
          else                           state_next = READ;
        end
      end
      READ:    state_next = (op_reg == OP_FADD) ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_LOAD;
      addr_reg  <= 8'h00;
      wdata_reg <= 8'h00;
      rdata_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        op_reg    <= op_norm;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        rdata_reg <= 8'h00;
      end
      // Memory data is only trusted while the read strobe is up.
      if (state_reg == READ) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rdata_reg;

  // Reset kills the strobes immediately so an interrupted cycle never commits.
  assign mem_read  = (state_reg == READ)  && !reset;
  assign mem_write = (state_reg == WRITE) && !reset;

  assign mem_addr  = (state_reg == IDLE) ? 8'h00 : addr_reg;

  always_comb begin
    mem_wdata = 8'h00;
    if (state_reg != IDLE) begin
      if (op_reg == OP_FADD && state_reg != READ) mem_wdata = fadd_sum;
      else                                        mem_wdata = wdata_reg;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit with a transaction-level memory model.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_FADD  = 2'b10;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  logic       mem_init;
  logic [7:0] phys_mem [32];
  logic [7:0] ref_mem  [32];

  int         rd_pulses = 0;
  int         wr_pulses = 0;
  int         both_high = 0;
  logic [7:0] last_rd_addr = 8'h00;
  logic [7:0] last_wr_addr = 8'h00;
  logic [7:0] last_wr_data = 8'h00;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = 8'(i);
    if (i == 20) v = 8'hFC;
    return v;
  endfunction

  // Physical data memory: asynchronous read, write on the clock edge.
  assign mem_rdata = mem_read ? phys_mem[mem_addr[4:0]] : 8'hzz;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) phys_mem[i] <= init_val(i);
    end else if (mem_write) begin
      phys_mem[mem_addr[4:0]] <= mem_wdata;
    end
    if (mem_read) begin
      rd_pulses    <= rd_pulses + 1;
      last_rd_addr <= mem_addr;
    end
    if (mem_write) begin
      wr_pulses    <= wr_pulses + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
    if (mem_read && mem_write) both_high <= both_high + 1;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"},  rsp_data,  0);
    check({tag, "_rsp_err"},   rsp_err,   0);
    check({tag, "_mem_read"},  mem_read,  0);
    check({tag, "_mem_write"}, mem_write, 0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Entered and left at 1ns after a clock edge with the unit idle.
  task automatic do_req(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata, input int hold);
    logic [7:0] exp_data;
    logic [7:0] exp_wval;
    logic       exp_err;
    int         exp_lat, exp_rd, exp_wr;
    int         rd0, wr0, lat, idx;

    idx      = int'(addr[4:0]);
    exp_err  = 1'b0;
    exp_wval = 8'h00;
`ifdef MEM_BOUNDS_CHECK_EN
    exp_err = (addr >= 8'd32);
`endif
    if (exp_err) begin
      exp_data = 8'h00; exp_lat = 1; exp_rd = 0; exp_wr = 0;
    end else if (op == OP_STORE) begin
      exp_data = 8'h00; exp_lat = 2; exp_rd = 0; exp_wr = 1;
      exp_wval = wdata;
      ref_mem[idx] = wdata;
    end else if (op == OP_FADD) begin
      exp_data = ref_mem[idx]; exp_lat = 3; exp_rd = 1; exp_wr = 1;
      exp_wval = 8'((int'(ref_mem[idx]) + int'(wdata)) % 256);
      ref_mem[idx] = exp_wval;
    end else begin
      exp_data = ref_mem[idx]; exp_lat = 2; exp_rd = 1; exp_wr = 0;
    end

    check("req_ready_idle", req_ready, 1);
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);

    lat = 1;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rsp_latency", lat, exp_lat);
    check("rsp_data", rsp_data, exp_data);
    check("rsp_err", rsp_err, exp_err);
    check("req_ready_busy", req_ready, 0);

    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_op    = 2'($urandom);
      @(posedge clk); #1;
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, exp_data);
      check("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);

    check("read_pulses", rd_pulses - rd0, exp_rd);
    check("write_pulses", wr_pulses - wr0, exp_wr);
    if (exp_rd == 1) check("read_addr", last_rd_addr, addr);
    if (exp_wr == 1) begin
      check("write_addr", last_wr_addr, addr);
      check("write_data", last_wr_data, exp_wval);
    end

    txn_no++;
    $display("txn %0d: op=%0d addr=0x%02h wdata=0x%02h -> data=0x%02h err=%0d lat=%0d hold=%0d",
             txn_no, op, addr, wdata, rsp_data, rsp_err, lat, hold);
  endtask

  initial begin
    logic [7:0] ra;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
    reset     = 1'b1;
    mem_init  = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_op    = 2'b00;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset    = 1'b0;
    mem_init = 1'b0;

    // Directed sequence from the test plan.
    do_req(OP_LOAD,  8'd5,  8'h00, 0);
    do_req(OP_LOAD,  8'd20, 8'h00, 0);
    do_req(OP_STORE, 8'd7,  8'hA5, 0);
    do_req(OP_LOAD,  8'd7,  8'h00, 0);
    do_req(OP_FADD,  8'd3,  8'hFE, 0);
    do_req(OP_LOAD,  8'd3,  8'h00, 0);
    do_req(OP_LOAD,  8'd11, 8'h00, 5);
    do_req(2'b11,    8'd12, 8'h77, 1);
    do_req(OP_LOAD,  8'd40, 8'h00, 0);

    // Fetch-and-add to word 9 interrupted by reset during its write cycle.
    req_op    = OP_FADD;
    req_addr  = 8'd9;
    req_wdata = 8'h33;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_wr_before", mem_write, 1);
    reset = 1'b1;
    #1;
    check("rst_wr_forced", mem_write, 0);
    @(posedge clk); #1;
    check_reset_outputs("midwrite");
    reset = 1'b0;
    do_req(OP_LOAD, 8'd9, 8'h00, 0);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) ra = 8'($urandom_range(32, 255));
      else                           ra = 8'($urandom_range(0, 31));
      do_req(2'($urandom_range(0, 3)), ra, 8'($urandom), int'($urandom_range(0, 3)));
    end

    check("strobe_overlap", both_high, 0);
    for (int i = 0; i < 32; i++) check($sformatf("mem_word_%0d", i), phys_mem[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
